led_trail_pwm: RTL

LED_TRAIL_PWM -- requirements
Module: led_trail_pwm

---
 rtl/led_trail_pwm.sv | 127 ++++++++++++
 1 files changed

// File: rtl/led_trail_pwm.sv
// ---------------------------------------------------------------------------
// led_trail_pwm
//
// PWM dimmer with an optional decaying "comet trail" for an 8-LED sweep.
// Each LED owns a brightness level. A lit input loads the global peak level;
// once the input drops, the level either fades one step per decay interval
// (trail build) or goes straight to zero (default build). A free-running PWM
// counter with period (2^LEVEL_W)-1 turns each level into a duty cycle of
// level/((2^LEVEL_W)-1).
//
// Build option:
//   LED_TRAIL_PWM_TRAIL_EN  - when defined, compile the decay prescaler and
//                             per-LED fade; when undefined, level follows
//                             led_in directly.
//
// Parameters:
//   LEVEL_W       width of each level register and of the PWM counter
//   DECAY_CYCLES  clk cycles between successive decay steps (>= 1)
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset_n     in   synchronous active-low reset
//   led_in      in   [7:0]  sweep pattern from the upstream stage
//   brightness  in   [LEVEL_W-1:0] peak level applied to lit LEDs
//   led_out     out  [7:0]  registered PWM drive to the LEDs
//   pwm_sync    out  registered one-cycle pulse at the start of each period
// ---------------------------------------------------------------------------
module led_trail_pwm #(
  parameter int unsigned LEVEL_W      = 4,
  parameter int unsigned DECAY_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         led_in,
  input  logic [LEVEL_W-1:0] brightness,
  output logic [7:0]         led_out,
  output logic               pwm_sync
);

  // Last PWM count is (2^LEVEL_W)-2, so the period is (2^LEVEL_W)-1 and the
  // all-ones level is on for every count.
  localparam logic [LEVEL_W-1:0] CNT_LAST = {{(LEVEL_W-1){1'b1}}, 1'b0};

  if (DECAY_CYCLES < 1) begin : g_bad_decay
    $error("led_trail_pwm: DECAY_CYCLES must be at least 1");
  end

  logic [LEVEL_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [LEVEL_W-1:0] level_q [8];
  logic [LEVEL_W-1:0] level_d [8];
  logic [7:0]         led_out_q, led_out_d;
  logic               pwm_sync_q, pwm_sync_d;

`ifdef LED_TRAIL_PWM_TRAIL_EN
  localparam int unsigned PRE_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DECAY_CYCLES - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             decay_tick;
`endif

  // NOTE: every always_comb target gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    pwm_cnt_d  = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + LEVEL_W'(1);
    pwm_sync_d = (pwm_cnt_q == '0);
    led_out_d  = '0;
    for (int i = 0; i < 8; i++) begin
      led_out_d[i] = (level_q[i] > pwm_cnt_q);
    end

`ifdef LED_TRAIL_PWM_TRAIL_EN
    decay_tick = (pre_q == PRE_LAST);
    pre_d      = decay_tick ? '0 : pre_q + PRE_W'(1);
    for (int i = 0; i < 8; i++) begin
      level_d[i] = level_q[i];
      // A lit input wins over a coincident decay step.
      if (led_in[i]) begin
        level_d[i] = brightness;
      end else if (decay_tick && (level_q[i] != '0)) begin
        level_d[i] = level_q[i] - LEVEL_W'(1);
      end
    end
`else
    for (int i = 0; i < 8; i++) begin
      level_d[i] = led_in[i] ? brightness : '0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its peers, independent of statement order.
  // NOTE: the level array is small and its reset value is visible at
  // led_out, so it is cleared alongside the counters rather than left as
  // uninitialised storage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_cnt_q  <= '0;
      led_out_q  <= '0;
      pwm_sync_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      led_out_q  <= led_out_d;
      pwm_sync_q <= pwm_sync_d;
      for (int i = 0; i < 8; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

`ifdef LED_TRAIL_PWM_TRAIL_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`endif

  assign led_out  = led_out_q;
  assign pwm_sync = pwm_sync_q;

endmodule
